saida_de_dados: RTL and testbench
=================================

// Module: saida_de_dados
// PURPOSE
//  Output unit of the CPU, the counterpart of the switch/button input unit. When the control unit
//  executes an OUT instruction it strobes OUT with a signed 32-bit word on dado.
//  The block latches the word and converts its magnitude to BCD with a sequential
//  double-dabble. It then drives N_DIGITOS active-low 7-segment digits plus a sign digit.
//  flag_OUT tells the control unit the unit is busy; pronto pulses when the display updates.
// PARAMETERS
//  N_DIGITOS  8   number of decimal digits displayed; legal range 1..9
// PORTS
//  clock      in   1              system clock, rising edge
//  reset      in   1              asynchronous, active-high reset
//  OUT        in   1              request from control unit; sampled each rising edge
//  dado       in   32             two's-complement value to display; sampled with OUT
//  segmentos  out  7*N_DIGITOS    digit k in [7k+6:7k] (k=0 is units); order {g,f,e,d,c,b,a}; active-low
//  sinal      out  7              sign digit, same encoding
//  flag_OUT   out  1              high while a conversion is in progress
//  pronto     out  1              one-cycle pulse when the displays take a new value
// BEHAVIOUR
//  Reset values (async, active-high):
//   - state OCIOSO; flag_OUT=0; pronto=0; sinal=7'b1111111 (blank).
//   - segmentos: units=7'b1000000 ("0"), all other digits 7'b1111111.
//  Encoding (active-low), digits 0..9:
//   - 1000000 1111001 0100100 0110000 0011001 0010010 0000010 1111000 0000000 0010000
//   - blank = 1111111; minus = 0111111; E = 0000110.
//  FSM states:
//   - OCIOSO: if OUT=1 at an edge, latch neg=dado[31] and mag=|dado| as 32-bit unsigned
//     (-2^31 gives 2^31); clear the BCD shift register; flag_OUT<=1; go to CONVERTE.
//     If OUT=0, stay.
//   - CONVERTE: 32 iterations, one per cycle, with a 5-bit counter.
//     Each cycle: add 3 to every BCD nibble >=5, then shift {bcd,mag} left by 1.
//     The BCD register is 4*N_DIGITOS bits.
//     After iteration 32, go to ATUALIZA.
//   - ATUALIZA, one cycle, updates segmentos/sinal:
//     * if mag > 10^N_DIGITOS-1: all digits=E and sinal=minus if neg;
//     * else: leading zeros blanked, units digit always shown, sinal=minus iff neg and mag!=0.
//     * pronto<=1 for this cycle; flag_OUT<=0; return to OCIOSO.
//  Timing:
//   - Latency: OUT accepted at edge T -> flag_OUT high from T.
//   - Displays and pronto change at edge T+33; flag_OUT low after edge T+33.
//   - Next OUT is accepted at T+34.
//  OUT while flag_OUT=1 is ignored; the request is dropped, with no queueing.
//  The control unit must hold the instruction until flag_OUT falls.
//  OUT held high continuously: a new conversion starts every 34 cycles.
//  Mag is captured at acceptance, so dado changes during CONVERTE have no effect.
//  Displays hold their last value between updates; they change only in ATUALIZA.
//  Reset mid-conversion aborts immediately; the displays return to reset values.
//  The overflow compare uses a 32-bit constant; N_DIGITOS=9 never overflows below 10^9.
//  The 2^31 case is still checked: 2147483648 > 999999999, so E is shown.
// TESTING
//  1 reset -> units=1000000, other digits blank, sinal blank, flag_OUT=0, pronto=0.
//  2 OUT=1, dado=32'd127 at T -> flag_OUT=1 during T..T+33; at T+33 digits "127", leading blanks, sinal blank, pronto=1 once.
//  3 dado=32'hFFFFFF80 (-128) -> digits "128", sinal=0111111; dado=0 -> units "0", sinal blank.
//  4 dado=32'd99999999 -> eight 9s; dado=32'd100000000 -> all E; dado=32'h80000000 -> all E, sinal minus.
//  5 OUT pulses again at T+5 with dado=5 -> ignored, display shows first value; dado changed during CONVERTE -> no effect.
//  6 reset asserted at T+10 of a conversion -> immediate reset values; a new OUT after release converts correctly in 34 cycles.

Source files
------------

// File: rtl/saida_de_dados.sv
// saida_de_dados -- CPU output unit.
//
// Accepts a signed 32-bit word when the control unit strobes OUT, converts its
// magnitude to BCD with a sequential double-dabble (one bit per clock, 32
// clocks), then drives N_DIGITOS active-low 7-segment digits plus a sign digit.
//
// Ports:
//   clock      in   1            system clock, rising edge
//   reset      in   1            asynchronous, active-high
//   OUT        in   1            output request, sampled each rising edge
//   dado       in   32           two's-complement value, sampled with OUT
//   segmentos  out  7*N_DIGITOS  digit k at [7k+6:7k], k=0 units, {g,f,e,d,c,b,a}, active-low
//   sinal      out  7            sign digit, same encoding
//   flag_OUT   out  1            high while a conversion is in progress
//   pronto     out  1            one-cycle pulse when the displays take a new value
module saida_de_dados #(
  parameter int N_DIGITOS = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     OUT,
  input  logic signed [31:0]       dado,
  output logic [7*N_DIGITOS-1:0]   segmentos,
  output logic [6:0]               sinal,
  output logic                     flag_OUT,
  output logic                     pronto
);

  localparam int BCD_W = 4 * N_DIGITOS;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  // Largest displayable magnitude; fits in 32 bits for every legal N_DIGITOS.
  localparam logic [31:0] LIMIT = 32'(pow10(N_DIGITOS) - 64'd1);

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Double-dabble correction: any nibble >=5 gets +3 so the following shift
  // carries correctly into the next decimal digit.
  function automatic logic [BCD_W-1:0] dabble_adj(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < N_DIGITOS; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [7*N_DIGITOS-1:0] reset_display();
    logic [7*N_DIGITOS-1:0] r;
    r = {(7*N_DIGITOS){1'b1}};
    r[6:0] = SEG_ZERO;
    return r;
  endfunction

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    CONVERTE = 2'd1,
    ATUALIZA = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [4:0]               cnt_q, cnt_d;
  logic [31:0]              mag_q, mag_d;
  logic [BCD_W-1:0]         bcd_q, bcd_d;
  logic                     neg_q, neg_d;
  logic                     ovf_q, ovf_d;
  logic                     nz_q, nz_d;
  logic [7*N_DIGITOS-1:0]   seg_q, seg_d;
  logic [6:0]               sinal_q, sinal_d;
  logic                     flag_q, flag_d;
  logic                     pronto_q, pronto_d;

  logic [31:0]              abs_dado;
  logic [BCD_W-1:0]         bcd_adj;
  logic [7*N_DIGITOS-1:0]   seg_new;
  logic                     leading;

  // Magnitude as unsigned: -2^31 wraps to 0x80000000, which is the right value.
  assign abs_dado = dado[31] ? (~dado + 32'd1) : dado;
  assign bcd_adj  = dabble_adj(bcd_q);

  // Display image built from the finished BCD register. Zeros are blanked
  // from the most significant digit down until the first non-zero digit;
  // the units digit is always shown.
  always_comb begin
    seg_new = {(7*N_DIGITOS){1'b1}};
    leading = 1'b1;
    for (int k = N_DIGITOS - 1; k >= 0; k--) begin
      if (ovf_q) begin
        seg_new[7*k +: 7] = SEG_E;
      end else if (leading && (bcd_q[4*k +: 4] == 4'd0) && (k != 0)) begin
        seg_new[7*k +: 7] = SEG_BLANK;
      end else begin
        seg_new[7*k +: 7] = seg7(bcd_q[4*k +: 4]);
        leading = 1'b0;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mag_d    = mag_q;
    bcd_d    = bcd_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    nz_d     = nz_q;
    seg_d    = seg_q;
    sinal_d  = sinal_q;
    flag_d   = flag_q;
    pronto_d = 1'b0;

    case (state_q)
      OCIOSO: begin
        if (OUT) begin
          neg_d   = dado[31];
          mag_d   = abs_dado;
          ovf_d   = abs_dado > LIMIT;
          nz_d    = abs_dado != 32'd0;
          bcd_d   = '0;
          cnt_d   = 5'd0;
          flag_d  = 1'b1;
          state_d = CONVERTE;
        end
      end
      CONVERTE: begin
        bcd_d = {bcd_adj[BCD_W-2:0], mag_q[31]};
        mag_d = {mag_q[30:0], 1'b0};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = ATUALIZA;
      end
      ATUALIZA: begin
        seg_d    = seg_new;
        sinal_d  = (neg_q && (ovf_q || nz_q)) ? SEG_MINUS : SEG_BLANK;
        pronto_d = 1'b1;
        flag_d   = 1'b0;
        state_d  = OCIOSO;
      end
      default: begin
        flag_d  = 1'b0;
        state_d = OCIOSO;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= OCIOSO;
      cnt_q    <= 5'd0;
      mag_q    <= '0;
      bcd_q    <= '0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      nz_q     <= 1'b0;
      seg_q    <= reset_display();
      sinal_q  <= SEG_BLANK;
      flag_q   <= 1'b0;
      pronto_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mag_q    <= mag_d;
      bcd_q    <= bcd_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
      nz_q     <= nz_d;
      seg_q    <= seg_d;
      sinal_q  <= sinal_d;
      flag_q   <= flag_d;
      pronto_q <= pronto_d;
    end
  end

  assign segmentos = seg_q;
  assign sinal     = sinal_q;
  assign flag_OUT  = flag_q;
  assign pronto    = pronto_q;

endmodule

// File: tb/tb_saida_de_dados.sv
module tb_saida_de_dados;

  logic               clock;
  logic               reset;
  logic               OUT;
  logic signed [31:0] dado;
  logic [55:0]        segmentos;
  logic [6:0]         sinal;
  logic               flag_OUT;
  logic               pronto;

  int total = 0;
  int bad   = 0;

  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] MINUS = 7'b0111111;

  saida_de_dados #(.N_DIGITOS(8)) dut (
    .clock    (clock),
    .reset    (reset),
    .OUT      (OUT),
    .dado     (dado),
    .segmentos(segmentos),
    .sinal    (sinal),
    .flag_OUT (flag_OUT),
    .pronto   (pronto)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected display from a hex-nibble digit map: 0-9 digit, E = letter E,
  // F = blank. Nibble k is digit k (units first).
  function automatic logic [55:0] disp(input logic [31:0] h);
    logic [55:0] r;
    logic [6:0]  s;
    for (int k = 0; k < 8; k++) begin
      case (h[4*k +: 4])
        4'h0: s = 7'b1000000;
        4'h1: s = 7'b1111001;
        4'h2: s = 7'b0100100;
        4'h3: s = 7'b0110000;
        4'h4: s = 7'b0011001;
        4'h5: s = 7'b0010010;
        4'h6: s = 7'b0000010;
        4'h7: s = 7'b1111000;
        4'h8: s = 7'b0000000;
        4'h9: s = 7'b0010000;
        4'hE: s = 7'b0000110;
        default: s = 7'b1111111;
      endcase
      r[7*k +: 7] = s;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction: strobe OUT at edge T, scramble dado afterwards,
  // check busy/pronto around T+32..T+34 and the display at T+33.
  task automatic run_conv(input string tag, input logic [31:0] val,
                          input logic [31:0] exp_h, input logic [6:0] exp_sig);
    @(negedge clock);
    OUT  = 1'b1;
    dado = val;
    @(posedge clock);
    #1;
    OUT  = 1'b0;
    dado = 32'h1234_5678;
    chk({tag, "_flag_T"}, 64'(flag_OUT), 64'd1);
    repeat (32) @(posedge clock);
    #1;
    chk({tag, "_flag_T32"}, 64'(flag_OUT), 64'd1);
    chk({tag, "_pronto_T32"}, 64'(pronto), 64'd0);
    @(posedge clock);
    #1;
    chk({tag, "_pronto_T33"}, 64'(pronto), 64'd1);
    chk({tag, "_flag_T33"}, 64'(flag_OUT), 64'd0);
    chk({tag, "_seg"}, 64'(segmentos), 64'(disp(exp_h)));
    chk({tag, "_sinal"}, 64'(sinal), 64'(exp_sig));
    @(posedge clock);
    #1;
    chk({tag, "_pronto_T34"}, 64'(pronto), 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    OUT   = 1'b0;
    dado  = '0;
    #12;
    chk("rst_seg", 64'(segmentos), 64'(disp(32'hFFFF_FFF0)));
    chk("rst_sinal", 64'(sinal), 64'(BLANK));
    chk("rst_flag", 64'(flag_OUT), 64'd0);
    chk("rst_pronto", 64'(pronto), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("idle_flag", 64'(flag_OUT), 64'd0);

    run_conv("p127", 32'd127, 32'hFFFF_F127, BLANK);
    run_conv("n128", 32'hFFFF_FF80, 32'hFFFF_F128, MINUS);
    run_conv("zero", 32'd0, 32'hFFFF_FFF0, BLANK);
    run_conv("max8", 32'd99999999, 32'h9999_9999, BLANK);
    run_conv("ovf", 32'd100000000, 32'hEEEE_EEEE, BLANK);
    run_conv("min32", 32'h8000_0000, 32'hEEEE_EEEE, MINUS);
    run_conv("n1", 32'hFFFF_FFFF, 32'hFFFF_FFF1, MINUS);
    run_conv("p1002", 32'd1002, 32'hFFFF_1002, BLANK);

    // Second OUT at T+5 must be dropped; display keeps the first value.
    @(negedge clock);
    OUT  = 1'b1;
    dado = 32'd4096;
    @(posedge clock);
    #1;
    OUT  = 1'b0;
    repeat (4) @(posedge clock);
    @(negedge clock);
    OUT  = 1'b1;
    dado = 32'd5;
    @(posedge clock);
    #1;
    OUT  = 1'b0;
    dado = 32'd777;
    chk("ign_flag_T5", 64'(flag_OUT), 64'd1);
    repeat (27) @(posedge clock);
    #1;
    chk("ign_pronto_T32", 64'(pronto), 64'd0);
    @(posedge clock);
    #1;
    chk("ign_pronto_T33", 64'(pronto), 64'd1);
    chk("ign_seg", 64'(segmentos), 64'(disp(32'hFFFF_4096)));
    chk("ign_sinal", 64'(sinal), 64'(BLANK));
    @(posedge clock);
    #1;
    chk("ign_flag_T34", 64'(flag_OUT), 64'd0);

    // Reset in the middle of a conversion aborts it immediately.
    @(negedge clock);
    OUT  = 1'b1;
    dado = -32'sd9;
    @(posedge clock);
    #1;
    OUT  = 1'b0;
    repeat (10) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_flag", 64'(flag_OUT), 64'd0);
    chk("mid_rst_seg", 64'(segmentos), 64'(disp(32'hFFFF_FFF0)));
    chk("mid_rst_sinal", 64'(sinal), 64'(BLANK));
    chk("mid_rst_pronto", 64'(pronto), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    run_conv("post_rst", 32'hFFFF_FFD3, 32'hFFFF_FF45, MINUS);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute safety bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
